// File: rtl/des_match_checker.sv
// Scans a stream of DES pipeline results for a target ciphertext and queues the
// candidate index of every hit in a small FIFO for a downstream consumer.
module des_match_checker #(
    parameter int unsigned IDX_W          = 32,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned NUM_CANDIDATES = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             pause,
    input  logic             restart_block,
    input  logic [1:64]      target,
    input  logic             result_valid,
    input  logic [1:64]      result,
    input  logic             match_pop,
    output logic             match_avail,
    output logic [IDX_W-1:0] match_index,
    output logic             overflow,
    output logic [IDX_W-1:0] checked_count,
    output logic             busy,
    output logic             done
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_FILL = CNT_W'(FIFO_DEPTH);
    localparam logic [IDX_W-1:0] LAST_CNT  = IDX_W'(NUM_CANDIDATES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSED,
        S_DONE
    } state_t;

    state_t            state, state_d;
    logic [IDX_W-1:0]  mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr, wr_ptr, rd_ptr_d, wr_ptr_d;
    logic [CNT_W-1:0]  fill, fill_d;
    logic [IDX_W-1:0]  count_d, index_d;
    logic              overflow_d, avail_d, busy_d, done_d;
    logic              accept, is_match, full, do_pop, do_push;

    // Next-state, FIFO bookkeeping and next values of every registered output
    always_comb begin
        state_d    = state;
        count_d    = checked_count;
        overflow_d = overflow;
        rd_ptr_d   = rd_ptr;
        wr_ptr_d   = wr_ptr;
        fill_d     = fill;
        index_d    = '0;

        accept   = result_valid && (state == S_RUN) && !pause;
        is_match = accept && (result == target);
        full     = (fill == FULL_FILL);
        do_pop   = match_pop && (fill != '0);
        // A full FIFO still takes the push when the head leaves in the same cycle
        do_push  = is_match && (!full || do_pop);

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_RUN;
                    count_d    = '0;
                    overflow_d = 1'b0;
                end
            end
            S_RUN: begin
                if (pause)
                    state_d = S_PAUSED;
                else if (accept && (checked_count + IDX_W'(1) == LAST_CNT))
                    state_d = S_DONE;
            end
            S_PAUSED: begin
                if (!pause)
                    state_d = S_RUN;
            end
            S_DONE: begin
                if (!start)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (accept)
            count_d = checked_count + IDX_W'(1);
        if (is_match && full && !do_pop)
            overflow_d = 1'b1;

        if (do_pop)
            rd_ptr_d = rd_ptr + PTR_W'(1);
        if (do_push)
            wr_ptr_d = wr_ptr + PTR_W'(1);
        if (do_push && !do_pop)
            fill_d = fill + CNT_W'(1);
        else if (!do_push && do_pop)
            fill_d = fill - CNT_W'(1);

        avail_d = (fill_d != '0);
        // New head is the entry being written whenever the old contents are all consumed
        if (avail_d)
            index_d = (do_push && (rd_ptr_d == wr_ptr)) ? checked_count : mem[rd_ptr_d];

        busy_d = (state_d == S_RUN) || (state_d == S_PAUSED);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst || restart_block) begin
            state         <= S_IDLE;
            checked_count <= '0;
            overflow      <= 1'b0;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            fill          <= '0;
            match_avail   <= 1'b0;
            match_index   <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            state         <= state_d;
            checked_count <= count_d;
            overflow      <= overflow_d;
            rd_ptr        <= rd_ptr_d;
            wr_ptr        <= wr_ptr_d;
            fill          <= fill_d;
            match_avail   <= avail_d;
            match_index   <= index_d;
            busy          <= busy_d;
            done          <= done_d;
        end
    end

    // Storage array needs no reset; occupancy is tracked by the pointers
    always_ff @(posedge clk) begin
        if (!rst && !restart_block && do_push)
            mem[wr_ptr] <= checked_count;
    end

endmodule

// File: tb/tb_des_match_checker.sv
// Directed bench for des_match_checker; a monitor pops the match FIFO and scores
// every presented index against a queue of expected indices.
module tb_des_match_checker;

    localparam int unsigned IDX_W = 16;
    localparam logic [1:64] TGT   = 64'h0123_4567_89AB_CDEF;
    localparam logic [1:64] OTHER = 64'hDEAD_BEEF_0000_1111;

    logic             clk = 1'b0;
    logic             rst, start, pause, restart_block, result_valid, match_pop;
    logic [1:64]      target, result;
    logic             match_avail, overflow, busy, done;
    logic [IDX_W-1:0] match_index, checked_count;

    int               tests  = 0;
    int               errors = 0;
    logic [IDX_W-1:0] exp_q[$];
    logic             pop_en = 1'b1;

    des_match_checker #(.IDX_W(IDX_W), .FIFO_DEPTH(4), .NUM_CANDIDATES(8)) dut (
        .clk(clk), .rst(rst), .start(start), .pause(pause),
        .restart_block(restart_block), .target(target),
        .result_valid(result_valid), .result(result), .match_pop(match_pop),
        .match_avail(match_avail), .match_index(match_index), .overflow(overflow),
        .checked_count(checked_count), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Monitor: scores the head each cycle it is offered and acknowledges it
    initial begin
        match_pop = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            match_pop = 1'b0;
            if (match_avail && pop_en && !rst) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_match", 64'(match_index), 64'hFFFF_FFFF);
                end else begin
                    chk("match_index", 64'(match_index), 64'(exp_q.pop_front()));
                end
                match_pop = 1'b1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; pause = 1'b0; restart_block = 1'b0;
        result_valid = 1'b0; result = OTHER; target = TGT;
        tick(); tick();
        rst = 1'b0;
        chk("rst_avail", 64'(match_avail), 0);
        chk("rst_index", 64'(match_index), 0);
        chk("rst_overflow", 64'(overflow), 0);
        chk("rst_count", 64'(checked_count), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_done", 64'(done), 0);

        // Match run: hit at candidate 5, start held through DONE
        start = 1'b1;
        tick();
        chk("run_busy", 64'(busy), 1);
        chk("run_count0", 64'(checked_count), 0);
        for (int i = 0; i < 8; i++) begin
            result_valid = 1'b1;
            result = (i == 5) ? TGT : OTHER;
            if (i == 5) exp_q.push_back(IDX_W'(5));
            tick();
            if (i == 4) chk("avail_before_hit", 64'(match_avail), 0);
            if (i == 5) begin
                chk("avail_after_hit", 64'(match_avail), 1);
                chk("index_after_hit", 64'(match_index), 5);
            end
        end
        chk("run_done", 64'(done), 1);
        chk("run_count8", 64'(checked_count), 8);
        chk("run_busy_end", 64'(busy), 0);

        // DONE ignores a matching result
        result = TGT;
        tick(); tick();
        chk("done_hold", 64'(done), 1);
        chk("done_count", 64'(checked_count), 8);
        chk("done_avail", 64'(match_avail), 0);
        result_valid = 1'b0;
        start = 1'b0;
        tick();
        chk("done_drop", 64'(done), 0);
        chk("idle_count_kept", 64'(checked_count), 8);

        // IDLE ignores a matching result
        result_valid = 1'b1; result = TGT;
        tick(); tick();
        chk("idle_count", 64'(checked_count), 8);
        chk("idle_avail", 64'(match_avail), 0);
        result_valid = 1'b0;

        // Pause with result_valid held, then restart mid-run with a pending hit
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("p_count0", 64'(checked_count), 0);
        result_valid = 1'b1; result = OTHER;
        tick(); tick();
        chk("p_count2", 64'(checked_count), 2);
        pause = 1'b1; result = TGT;
        tick(); tick(); tick();
        chk("p_count_frozen", 64'(checked_count), 2);
        chk("p_busy", 64'(busy), 1);
        chk("p_no_match", 64'(match_avail), 0);
        pause = 1'b0; result = OTHER;
        tick();
        chk("p_resume_cycle", 64'(checked_count), 2);
        tick();
        chk("p_count3", 64'(checked_count), 3);
        restart_block = 1'b1; result = TGT;
        tick();
        restart_block = 1'b0; result_valid = 1'b0;
        chk("rb_busy", 64'(busy), 0);
        chk("rb_count", 64'(checked_count), 0);
        chk("rb_avail", 64'(match_avail), 0);
        chk("rb_done", 64'(done), 0);

        // Overflow: five hits, no pops
        pop_en = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            result_valid = 1'b1; result = TGT;
            if (i < 4) exp_q.push_back(IDX_W'(i));
            tick();
        end
        result_valid = 1'b0;
        chk("ov_flag", 64'(overflow), 1);
        chk("ov_avail", 64'(match_avail), 1);
        chk("ov_head", 64'(match_index), 0);
        chk("ov_count", 64'(checked_count), 5);
        pop_en = 1'b1;
        repeat (8) tick();
        chk("ov_drained", 64'(match_avail), 0);
        chk("ov_queue_empty", 64'(exp_q.size()), 0);
        chk("ov_sticky", 64'(overflow), 1);

        // Full FIFO: push and pop in the same cycle
        restart_block = 1'b1;
        tick();
        restart_block = 1'b0;
        chk("fp_ov_cleared", 64'(overflow), 0);
        pop_en = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            result_valid = 1'b1; result = TGT;
            exp_q.push_back(IDX_W'(i));
            if (i == 3) pop_en = 1'b1;
            tick();
        end
        result_valid = 1'b0;
        chk("fp_no_overflow", 64'(overflow), 0);
        chk("fp_count", 64'(checked_count), 5);
        repeat (8) tick();
        chk("fp_drained", 64'(match_avail), 0);
        chk("fp_queue_empty", 64'(exp_q.size()), 0);
        chk("fp_overflow_end", 64'(overflow), 0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
